// File: rtl/alu_exec.sv
// Single-issue ALU execute stage: one-cycle logic/arithmetic ops, shifts
// iterated one bit per cycle, result held under a valid/ready output handshake.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and data is stable while valid.
  state_t           state, state_next;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] work, work_shifted, alu_out;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    shamt;
  logic             accept, is_shift, shift_multi;

  assign in_ready    = (state == IDLE) && reset_n;
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign shamt       = op_b[SW-1:0];
  assign is_shift    = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign shift_multi = is_shift && (shamt != '0);

  // Shift codes yield op_a here; this path is only taken for a zero amount.
  always_comb begin
    alu_out = op_a + op_b;
    case (alu_ctrl)
      OP_SUB:  alu_out = op_a - op_b;
      OP_SLL:  alu_out = op_a;
      OP_SRL:  alu_out = op_a;
      OP_SRA:  alu_out = op_a;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_AND:  alu_out = op_a & op_b;
      default: alu_out = op_a + op_b;
    endcase
  end

  always_comb begin
    work_shifted = work >> 1;
    case (ctrl_q)
      OP_SLL:  work_shifted = work << 1;
      OP_SRA:  work_shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_shifted = work >> 1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = shift_multi ? SHIFT : DONE;
      SHIFT:   if (cnt == SW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      ctrl_q <= '0;
      work   <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl_q <= alu_ctrl;
            if (shift_multi) begin
              work <= op_a;
              cnt  <= shamt;
            end else begin
              result <= alu_out;
              zero   <= (alu_out == '0);
            end
          end
        end
        SHIFT: begin
          work <= work_shifted;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result <= work_shifted;
            zero   <= (work_shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: driver issues ops and queues expected results;
// a negedge monitor pops and compares on every output transfer.
module tb_alu_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  logic [W:0]   exp_q[$];
  int total = 0;
  int bad   = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: each output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got result 0x%08h with empty queue", result);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({zero, result} !== e) begin
          bad++;
          $display("FAIL scoreboard: got zero=%0b result=0x%08h expected zero=%0b result=0x%08h",
                   zero, result, e[W], e[W-1:0]);
        end
      end
    end
  end

  // Issue one op, queue its expected output, and check accept-to-valid latency.
  // Returns at posedge+1 of the first out_valid cycle.
  task automatic issue(input string name, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    exp_q.push_back({(er == '0), er});
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; alu_ctrl = 4'($urandom_range(0, 15));
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, W'(n), W'(lat));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", W'(out_valid), W'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_result", result, W'(0));
    check("rst_zero", W'(zero), W'(0));
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;

    issue("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1); drain();
    issue("sub_zero", 4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1); drain();
    issue("sra4", 4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5); drain();
    issue("srl4", 4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5); drain();
    issue("slt", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1); drain();
    issue("xor", 4'b0100, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1); drain();
    issue("or", 4'b0110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1); drain();
    issue("and", 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1); drain();
    issue("unused_1111", 4'b1111, 32'd5, 32'd3, 32'd8, 1); drain();
    issue("sll_amt0", 4'b0001, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1); drain();
    issue("sll_amt3", 4'b0001, 32'h0000_0005, 32'h0000_0023, 32'h0000_0028, 4); drain();
    issue("sll31", 4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32); drain();
    issue("sra1_pos", 4'b1101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 2); drain();

    // Backpressure: result held, new request ignored until the DONE->IDLE edge
    out_ready = 1'b0;
    issue("sltu_bp", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = 32'd2; op_b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_result", result, W'(0));
      check("bp_zero", W'(zero), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_out_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 32'd5});
    @(posedge clk); #1;
    check("ii2_out_valid", W'(out_valid), W'(0));
    check("ii2_busy", W'(busy), W'(0));
    check("ii2_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ii2_accept", W'(out_valid), W'(1));
    drain();

    // Reset during the third SHIFT cycle discards the op
    in_valid = 1'b1; alu_ctrl = 4'b0001; op_a = 32'h1; op_b = 32'h1F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_shift_busy", W'(busy), W'(1));
    reset_n = 1'b0;
    #1;
    check("rst_low_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_result", result, W'(0));
    reset_n = 1'b1;
    #1;
    check("midrst_in_ready", W'(in_ready), W'(1));
    repeat (40) @(posedge clk);
    #1;
    check("no_stale_busy", W'(busy), W'(0));

    issue("post_rst_add", 4'b0000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1); drain();

    repeat (2) @(posedge clk);
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
